// File: rtl/mem_slave_pkg.sv
// Shared types and constants for the mem_slave addressed storage slave.
// Optional parity storage is enabled with MEM_SLAVE_PARITY_EN.
package mem_slave_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;
    localparam int BURST_MAX  = 15;
    localparam int CNT_MAX    = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } phase_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'(CNT_MAX)) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem_slave_array.sv
// 2**ADDR_W x DATA_W register array: async clear, one write port, registered read port.
// With MEM_SLAVE_PARITY_EN an even-parity bit is stored per entry and checked on read.
module mem_slave_array
    import mem_slave_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
`ifdef MEM_SLAVE_PARITY_EN
    ,
    output logic              perr
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // rdata holds its last value between reads; only rvalid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= mem_q[addr];
            end
        end
    end

`ifdef MEM_SLAVE_PARITY_EN
    // Packed so a single stored parity bit can be addressed directly.
    logic [DEPTH-1:0] par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= '0;
        end else if (we) begin
            par_q[addr] <= ^wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr <= 1'b0;
        end else if (re) begin
            perr <= (^mem_q[addr]) != par_q[addr];
        end else begin
            perr <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/mem_slave.sv
// Addressed storage slave: write / registered read of a register array plus bus-phase,
// burst-length, direction-change and access-count tracking. Parity option: MEM_SLAVE_PARITY_EN.
//
// state | meaning
// IDLE  | no access sampled on the last edge
// WRITE | a write was sampled on the last edge
// READ  | a read was sampled on the last edge
module mem_slave
    import mem_slave_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [1:0]        phase,
    output logic [3:0]        burst_len,
    output logic              dir_switch,
    output logic [7:0]        wr_cnt,
    output logic [7:0]        rd_cnt
`ifdef MEM_SLAVE_PARITY_EN
    ,
    output logic              perr
`endif
);

    logic   we;
    logic   re;
    phase_e phase_q, phase_d;
    logic [3:0] burst_q, burst_d;
    logic   dir_q, dir_d;
    logic [7:0] wr_cnt_q, wr_cnt_d;
    logic [7:0] rd_cnt_q, rd_cnt_d;

    assign we = en & wr;
    assign re = en & ~wr;

    mem_slave_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .re     (re),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid)
`ifdef MEM_SLAVE_PARITY_EN
        ,
        .perr   (perr)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= IDLE;
            burst_q  <= '0;
            dir_q    <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            phase_q  <= phase_d;
            burst_q  <= burst_d;
            dir_q    <= dir_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        phase_d  = IDLE;
        burst_d  = '0;
        dir_d    = 1'b0;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;

        if (en) begin
            phase_d = wr ? WRITE : READ;
        end

        if (phase_d != IDLE) begin
            if (phase_d == phase_q) begin
                burst_d = (burst_q == 4'(BURST_MAX)) ? burst_q : burst_q + 4'd1;
            end else begin
                burst_d = 4'd1;
            end
        end

        // Only a direct hop between the two active phases counts; via IDLE does not.
        dir_d = ((phase_q == WRITE) && (phase_d == READ)) ||
                ((phase_q == READ)  && (phase_d == WRITE));

        if (we) begin
            wr_cnt_d = sat_inc8(wr_cnt_q);
        end
        if (re) begin
            rd_cnt_d = sat_inc8(rd_cnt_q);
        end
    end

    assign phase      = phase_q;
    assign burst_len  = burst_q;
    assign dir_switch = dir_q;
    assign wr_cnt     = wr_cnt_q;
    assign rd_cnt     = rd_cnt_q;

endmodule
